// File: rtl/morph_pkg.sv
// Shared encodings and helpers for the 3x3 morphology window.
package morph_pkg;

    typedef enum logic [0:0] {
        ST_LINE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic MODE_ERODE   = 1'b0;
    localparam logic MODE_DILATE  = 1'b1;
    localparam logic SHAPE_CROSS  = 1'b0;
    localparam logic SHAPE_SQUARE = 1'b1;

    // Identity element of the reduction: all-ones for min, zero for max (ch_w <= 64).
    function automatic logic [63:0] neutral_val(input logic mode, input int unsigned ch_w);
        logic [63:0] v;
        v = '0;
        if (mode == MODE_ERODE) begin
            v = ~64'd0 >> (7'd64 - 7'(ch_w));
        end
        return v;
    endfunction

endpackage

// File: rtl/morph_sel2.sv
// Unsigned min (erode) or max (dilate) of two channel values.
module morph_sel2
    import morph_pkg::*;
#(
    parameter int unsigned CH_W = 8
) (
    input  logic [CH_W-1:0] a,
    input  logic [CH_W-1:0] b,
    input  logic            mode,
    output logic [CH_W-1:0] y
);

    always_comb begin
        if (mode == MODE_DILATE) begin
            y = (a > b) ? a : b;
        end else begin
            y = (a < b) ? a : b;
        end
    end

endmodule

// File: rtl/morph_window_3x3.sv
// 3x3 erosion/dilation window with cross/square kernel, border padding and end-of-line flush.
module morph_window_3x3
    import morph_pkg::*;
#(
    parameter int unsigned PIC_WIDTH = 250,
    parameter int unsigned NUM_CH    = 3,
    parameter int unsigned CH_W      = 8,
    parameter int unsigned CNT_W     = $clog2(PIC_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_in,
    output logic                   in_ready,
    input  logic [NUM_CH*CH_W-1:0] row_top,
    input  logic [NUM_CH*CH_W-1:0] row_mid,
    input  logic [NUM_CH*CH_W-1:0] row_bot,
    input  logic                   top_pad,
    input  logic                   bot_pad,
    input  logic                   mode,
    input  logic                   shape,
    output logic [NUM_CH*CH_W-1:0] dout,
    output logic                   valid_out,
    output logic                   eol_out
);

    localparam int unsigned PX_W = NUM_CH * CH_W;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mode_q, shape_q, top_pad_q, bot_pad_q;
    logic [PX_W-1:0]  win_q [3][3];  // [row: top/mid/bot][col: left/centre/right]
    logic             emit_q, eol_e_q, ctr0_q;
    logic [PX_W-1:0]  s1_q [3];
    logic             v1_q, eol1_q, mode1_q;

    logic             accept, flush, shift, col0, last_col;
    logic             eff_mode, eff_top, eff_bot;
    logic [CH_W-1:0]  neu_eff, neu_q;
    logic [PX_W-1:0]  in_top, in_mid, in_bot;
    wire  [PX_W-1:0]  s1_d [3];
    wire  [PX_W-1:0]  res_d;

    assign accept   = valid_in & in_ready;
    assign flush    = (state_q == ST_FLUSH);
    assign shift    = accept | flush;
    assign col0     = accept && (cnt_q == '0);
    assign last_col = (cnt_q == CNT_W'(PIC_WIDTH - 1));

    // Column 0 uses the live configuration since it is latched on that same edge.
    assign eff_mode = col0 ? mode    : mode_q;
    assign eff_top  = col0 ? top_pad : top_pad_q;
    assign eff_bot  = col0 ? bot_pad : bot_pad_q;
    assign neu_eff  = CH_W'(neutral_val(eff_mode, CH_W));
    assign neu_q    = CH_W'(neutral_val(mode_q, CH_W));

    always_comb begin
        in_top = row_top;
        in_mid = row_mid;
        in_bot = row_bot;
        if (flush) begin
            in_top = {NUM_CH{neu_q}};
            in_mid = {NUM_CH{neu_q}};
            in_bot = {NUM_CH{neu_q}};
        end else begin
            if (eff_top) in_top = {NUM_CH{neu_eff}};
            if (eff_bot) in_bot = {NUM_CH{neu_eff}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_LINE;
            in_ready  <= 1'b1;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            shape_q   <= 1'b0;
            top_pad_q <= 1'b0;
            bot_pad_q <= 1'b0;
            emit_q    <= 1'b0;
            eol_e_q   <= 1'b0;
            ctr0_q    <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            if (accept) begin
                cnt_q <= last_col ? '0 : cnt_q + CNT_W'(1);
            end
            if (col0) begin
                mode_q    <= mode;
                shape_q   <= shape;
                top_pad_q <= top_pad;
                bot_pad_q <= bot_pad;
            end
            case (state_q)
                ST_LINE: begin
                    if (accept && last_col) begin
                        state_q  <= ST_FLUSH;
                        in_ready <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_LINE;
                    in_ready <= 1'b1;
                end
            endcase
            if (shift) begin
                win_q[0][0] <= win_q[0][1];
                win_q[0][1] <= win_q[0][2];
                win_q[0][2] <= in_top;
                win_q[1][0] <= win_q[1][1];
                win_q[1][1] <= win_q[1][2];
                win_q[1][2] <= in_mid;
                win_q[2][0] <= win_q[2][1];
                win_q[2][1] <= win_q[2][2];
                win_q[2][2] <= in_bot;
            end
            emit_q  <= flush || (accept && (cnt_q != '0));
            eol_e_q <= flush;
            ctr0_q  <= accept && (cnt_q == CNT_W'(1));
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        localparam int unsigned LO = ch * CH_W;
        wire [CH_W-1:0] col_red [3];
        wire [CH_W-1:0] pair01;

        for (genvar j = 0; j < 3; j++) begin : g_col
            wire [CH_W-1:0] top_mid;
            morph_sel2 #(.CH_W(CH_W)) u_sel_tm (
                .a    (win_q[0][j][LO +: CH_W]),
                .b    (win_q[1][j][LO +: CH_W]),
                .mode (mode_q),
                .y    (top_mid)
            );
            morph_sel2 #(.CH_W(CH_W)) u_sel_col (
                .a    (top_mid),
                .b    (win_q[2][j][LO +: CH_W]),
                .mode (mode_q),
                .y    (col_red[j])
            );
        end

        // Square reduces whole columns; cross reduces the centre column plus left/right mid pixels.
        assign s1_d[0][LO +: CH_W] = shape_q ? (ctr0_q ? neu_q : col_red[0]) : col_red[1];
        assign s1_d[1][LO +: CH_W] = shape_q ? col_red[1]
                                             : (ctr0_q ? neu_q : win_q[1][0][LO +: CH_W]);
        assign s1_d[2][LO +: CH_W] = shape_q ? col_red[2] : win_q[1][2][LO +: CH_W];

        morph_sel2 #(.CH_W(CH_W)) u_sel_s2a (
            .a    (s1_q[0][LO +: CH_W]),
            .b    (s1_q[1][LO +: CH_W]),
            .mode (mode1_q),
            .y    (pair01)
        );
        morph_sel2 #(.CH_W(CH_W)) u_sel_s2b (
            .a    (pair01),
            .b    (s1_q[2][LO +: CH_W]),
            .mode (mode1_q),
            .y    (res_d[LO +: CH_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                s1_q[k] <= '0;
            end
            v1_q      <= 1'b0;
            eol1_q    <= 1'b0;
            mode1_q   <= 1'b0;
            dout      <= '0;
            valid_out <= 1'b0;
            eol_out   <= 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                s1_q[k] <= s1_d[k];
            end
            v1_q      <= emit_q;
            eol1_q    <= eol_e_q;
            mode1_q   <= mode_q;
            valid_out <= v1_q;
            eol_out   <= v1_q & eol1_q;
            if (v1_q) begin
                dout <= res_d;
            end
        end
    end

endmodule

// File: tb/tb_morph_window_3x3.sv
// Scoreboard bench for morph_window_3x3 with a 4-pixel line and three 8-bit channels.
module tb_morph_window_3x3;

    localparam int PW = 4;
    localparam int NC = 3;
    localparam int CW = 8;
    localparam int DW = NC * CW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_in = 1'b1;
    logic          in_ready;
    logic [DW-1:0] row_top = '0, row_mid = '0, row_bot = '0;
    logic          top_pad = 1'b0, bot_pad = 1'b0, mode = 1'b0, shape = 1'b0;
    logic [DW-1:0] dout;
    logic          valid_out, eol_out;

    always #5 clk = ~clk;

    morph_window_3x3 #(
        .PIC_WIDTH (PW),
        .NUM_CH    (NC),
        .CH_W      (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .in_ready  (in_ready),
        .row_top   (row_top),
        .row_mid   (row_mid),
        .row_bot   (row_bot),
        .top_pad   (top_pad),
        .bot_pad   (bot_pad),
        .mode      (mode),
        .shape     (shape),
        .dout      (dout),
        .valid_out (valid_out),
        .eol_out   (eol_out)
    );

    typedef struct packed {
        logic [DW-1:0] px;
        logic          eol;
    } exp_t;

    exp_t          exp_q[$];
    int            vedge_q[$];
    int            checks = 0;
    int            errors = 0;
    int            edge_cnt = 0;
    int            acc_edge[PW];
    logic [DW-1:0] l_top[PW], l_mid[PW], l_bot[PW];
    int            dil_top[PW] = '{1, 2, 3, 99};

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            vedge_q.push_back(edge_cnt);
            if (exp_q.size() == 0) begin
                check_val("spurious_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_val("dout", dout, e.px);
                check_val("eol_out", eol_out, e.eol);
            end
        end
    end

    function automatic logic [DW-1:0] rep(input logic [CW-1:0] v);
        return {NC{v}};
    endfunction

    // Straightforward neighbourhood evaluation over a neutral-padded image.
    function automatic logic [DW-1:0] model_px(input int x, input logic md, input logic sh,
                                               input logic tp, input logic bp);
        logic [DW-1:0] r;
        logic [CW-1:0] neu, acc, v;
        int            xx;
        r = '0;
        for (int ch = 0; ch < NC; ch++) begin
            neu = md ? '0 : '1;
            acc = neu;
            for (int dy = -1; dy <= 1; dy++) begin
                for (int dx = -1; dx <= 1; dx++) begin
                    if (!sh && dy != 0 && dx != 0) continue;
                    xx = x + dx;
                    if (xx < 0 || xx >= PW) v = neu;
                    else if (dy == -1) v = tp ? neu : l_top[xx][ch*CW +: CW];
                    else if (dy == 1) v = bp ? neu : l_bot[xx][ch*CW +: CW];
                    else v = l_mid[xx][ch*CW +: CW];
                    acc = md ? ((v > acc) ? v : acc) : ((v < acc) ? v : acc);
                end
            end
            r[ch*CW +: CW] = acc;
        end
        return r;
    endfunction

    task automatic drive_col(input int c, input logic md, input logic sh, input logic tp,
                             input logic bp, input bit gaps);
        int tries;
        int n;
        if (gaps) begin
            n = $urandom_range(0, 2);
            repeat (n) begin
                @(negedge clk);
                valid_in = 1'b0;
            end
        end
        @(negedge clk);
        row_top = l_top[c];
        row_mid = l_mid[c];
        row_bot = l_bot[c];
        mode    = md;
        shape   = sh;
        top_pad = tp;
        bot_pad = bp;
        tries   = 0;
        while (in_ready !== 1'b1 && tries < 8) begin
            valid_in = (gaps && $urandom_range(0, 1) == 1) ? 1'b0 : 1'b1;
            @(negedge clk);
            tries++;
        end
        if (in_ready !== 1'b1) begin
            check_val("ready_wait", 32'd0, 32'd1);
            valid_in = 1'b0;
            return;
        end
        valid_in    = 1'b1;
        acc_edge[c] = edge_cnt + 1;
        @(posedge clk);
    endtask

    task automatic run_line(input logic md, input logic sh, input logic tp, input logic bp,
                            input bit gaps, input bit scramble);
        for (int x = 0; x < PW; x++) begin
            exp_q.push_back('{px: model_px(x, md, sh, tp, bp), eol: 1'(x == PW - 1)});
        end
        for (int c = 0; c < PW; c++) begin
            if (scramble && c > 0) drive_col(c, ~md, ~sh, ~tp, ~bp, gaps);
            else drive_col(c, md, sh, tp, bp, gaps);
        end
    endtask

    task automatic idle_drain();
        int n;
        @(negedge clk);
        valid_in = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check_val("drain", exp_q.size(), 32'd0);
    endtask

    task automatic load_ramp();
        for (int i = 0; i < PW; i++) begin
            l_mid[i] = rep(CW'(10 * (i + 1)));
            l_top[i] = rep(8'd50);
            l_bot[i] = rep(8'd50);
        end
    endtask

    initial begin
        // Reset held with valid_in asserted.
        repeat (3) @(negedge clk);
        check_val("rst_dout", dout, 32'd0);
        check_val("rst_valid_out", valid_out, 32'd0);
        check_val("rst_eol_out", eol_out, 32'd0);
        check_val("rst_in_ready", in_ready, 32'd1);
        rst = 1'b0;
        valid_in = 1'b0;
        vedge_q.delete();

        // Erode, cross: expected 10,10,20,30.
        load_ramp();
        run_line(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_val("flush_ready_lo", in_ready, 32'd0);
        valid_in = 1'b0;
        @(negedge clk);
        check_val("flush_ready_hi", in_ready, 32'd1);
        idle_drain();
        check_val("first_latency", (vedge_q.size() > 0) ? vedge_q[0] : 0, acc_edge[1] + 2);

        // Dilate: square 5,5,99,99 then cross 5,5,5,99.
        for (int i = 0; i < PW; i++) begin
            l_top[i] = rep(CW'(dil_top[i]));
            l_mid[i] = rep(8'd5);
            l_bot[i] = rep(8'd0);
        end
        run_line(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_line(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_drain();

        // Padding, erode; scrambled lines change config mid-line.
        for (int i = 0; i < PW; i++) begin
            l_top[i] = rep(8'd0);
            l_mid[i] = rep(8'd100);
            l_bot[i] = rep(8'd200);
        end
        run_line(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_line(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_line(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_line(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        idle_drain();

        // Channel independence: column 0 must be 0x101080.
        l_mid = '{24'h10FF80, 24'h8010FF, 24'hFFFFFF, 24'hFFFFFF};
        for (int i = 0; i < PW; i++) begin
            l_top[i] = DW'($urandom());
            l_bot[i] = DW'($urandom());
        end
        run_line(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle_drain();

        // Random valid_in gaps, including during FLUSH.
        load_ramp();
        repeat (3) run_line(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < PW; i++) begin
            l_top[i] = rep(CW'(dil_top[i]));
            l_mid[i] = rep(8'd5);
            l_bot[i] = rep(8'd0);
        end
        repeat (3) run_line(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_drain();

        // Reset at column 2 discards the partial line; the next line is intact.
        load_ramp();
        drive_col(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_col(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        valid_in = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        run_line(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
